gf16_div: RTL

GF16_DIV -- requirements
Module: gf16_div

---
 rtl/gf16_div_if.sv | 21 ++
 rtl/gf16_div.sv | 101 ++++++++++
 2 files changed

// File: rtl/gf16_div_if.sv
// rtl/gf16_div_if.sv - operand/result handshake bundle for the GF(2^4) divider
interface gf16_div_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic       div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero
  );
endinterface

// File: rtl/gf16_div.sv
// rtl/gf16_div.sv - GF(2^4) divider, P(x)=x^4+x^3+1, inverse as b^14 via square-and-multiply
module gf16_div (
  input  logic        clk,
  input  logic        rst_n,
  gf16_div_if.slave   bus_io
);

  typedef enum logic [2:0] {IDLE, INV1, INV2, INV3, MUL, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] q_q, q_d;
  logic       dbz_q, dbz_d;

  // Carry-less 4x4 product folded back with x^4=x^3+1, x^5=x^3+x+1, x^6=x^3+x^2+x+1.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ ({3'b000, x} << i);
    end
    gf_mul = p[3:0]
           ^ (p[4] ? 4'h9 : 4'h0)
           ^ (p[5] ? 4'hB : 4'h0)
           ^ (p[6] ? 4'hF : 4'h0);
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 4'h0;
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      q_q   <= 4'h0;
      dbz_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      dbz_q <= dbz_d;
    end
  end

  // Next-state and datapath: b^3 -> b^7 -> b^14 = b^-1, then a * b^-1.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.a;
          b_d     = bus_io.b;
          acc_d   = bus_io.b;
          state_d = INV1;
        end
      end
      INV1: begin
        acc_d   = gf_mul(gf_mul(acc_q, acc_q), b_q);
        state_d = INV2;
      end
      INV2: begin
        acc_d   = gf_mul(gf_mul(acc_q, acc_q), b_q);
        state_d = INV3;
      end
      INV3: begin
        acc_d   = gf_mul(acc_q, acc_q);
        state_d = MUL;
      end
      MUL: begin
        // b = 0 falls out naturally as 0^14 = 0, so q is 0 with the flag set.
        q_d     = gf_mul(a_q, acc_q);
        dbz_d   = (b_q == 4'h0);
        state_d = DONE;
      end
      DONE: begin
        if (bus_io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode directly from state.
  assign bus_io.in_ready    = (state_q == IDLE);
  assign bus_io.out_valid   = (state_q == DONE);
  assign bus_io.q           = q_q;
  assign bus_io.div_by_zero = dbz_q;

endmodule
